// File: rtl/audio_pkg.sv
// Shared types for the PCM sample path: sample width, sample type and the
// read-side prefetch FSM state encoding.
package audio_pkg;
  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    RB_EMPTY,
    RB_FETCH,
    RB_VALID
  } rdbuf_state_t;
endpackage

// File: rtl/pcm_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The array has no reset, which lets it map onto block RAM.
module pcm_sdp_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pcm_sample_buffer.sv
// Circular buffer for PCM samples: unthrottled write side, ready/valid read
// side fed by a prefetch FSM so the presented data and valid are registers.
module pcm_sample_buffer #(
  parameter int SAMPLE_W    = 24,
  parameter int DEPTH       = 1024,
  parameter int READY_LEVEL = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [SAMPLE_W-1:0]        sample_i,
  input  logic                       sample_valid_i,
  input  logic                       flush_i,
  output logic [SAMPLE_W-1:0]        ram_read_data_o,
  output logic                       ram_read_valid_o,
  input  logic                       ram_read_ready_i,
  output logic                       ram_buffer_ready_o,
  output logic [$clog2(DEPTH):0]     fill_count_o,
  output logic                       overflow_o
);
  import audio_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rdbuf_state_t        state_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [SAMPLE_W-1:0] data_q;
  logic                valid_q, buf_rdy_q, ovf_q;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                full, has_data, wr_accept, rd_issue, going_empty;

  always_comb begin
    full        = (count_q == CW'(DEPTH));
    has_data    = (count_q != '0);
    wr_accept   = sample_valid_i & ~full & ~flush_i;
    rd_issue    = ~flush_i & has_data &
                  ((state_q == RB_EMPTY) | ((state_q == RB_VALID) & ram_read_ready_i));
    going_empty = ~has_data &
                  ((state_q == RB_EMPTY) | ((state_q == RB_VALID) & ram_read_ready_i));
    count_d     = count_q + CW'(wr_accept) - CW'(rd_issue);
  end

  pcm_sdp_ram #(.DEPTH(DEPTH), .W(SAMPLE_W), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample_i),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RB_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      buf_rdy_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (flush_i) begin
      // Any read already in flight is dropped by forcing EMPTY.
      state_q   <= RB_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      buf_rdy_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_issue)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (sample_valid_i && full) ovf_q <= 1'b1;
      if (count_d >= CW'(READY_LEVEL))           buf_rdy_q <= 1'b1;
      else if (count_d == '0 && going_empty)     buf_rdy_q <= 1'b0;

      case (state_q)
        RB_EMPTY: if (rd_issue) state_q <= RB_FETCH;
        RB_FETCH: begin
          data_q  <= ram_rdata;
          valid_q <= 1'b1;
          state_q <= RB_VALID;
        end
        RB_VALID: if (ram_read_ready_i) begin
          valid_q <= 1'b0;
          state_q <= has_data ? RB_FETCH : RB_EMPTY;
        end
        default: state_q <= RB_EMPTY;
      endcase
    end
  end

  assign ram_read_data_o    = data_q;
  assign ram_read_valid_o   = valid_q;
  assign ram_buffer_ready_o = buf_rdy_q;
  assign fill_count_o       = count_q;
  assign overflow_o         = ovf_q;

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Scoreboard bench for pcm_sample_buffer (DEPTH=8, READY_LEVEL=4): stimulus
// pushes expected samples, a negedge monitor pops them on each handshake.
module tb_pcm_sample_buffer;
  localparam int SW = 24;
  localparam int DP = 8;
  localparam int RL = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [SW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [SW-1:0] ram_read_data_o;
  logic          ram_read_valid_o;
  logic          ram_read_ready_i = 1'b0;
  logic          ram_buffer_ready_o;
  logic [3:0]    fill_count_o;
  logic          overflow_o;

  int vectors = 0;
  int miscompares = 0;
  logic [SW-1:0] exp_q [$];

  pcm_sample_buffer #(.SAMPLE_W(SW), .DEPTH(DP), .READY_LEVEL(RL)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .sample_i           (sample_i),
    .sample_valid_i     (sample_valid_i),
    .flush_i            (flush_i),
    .ram_read_data_o    (ram_read_data_o),
    .ram_read_valid_o   (ram_read_valid_o),
    .ram_read_ready_i   (ram_read_ready_i),
    .ram_buffer_ready_o (ram_buffer_ready_o),
    .fill_count_o       (fill_count_o),
    .overflow_o         (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake completes on the next posedge; the expected sample is popped here.
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i && ram_read_valid_o && ram_read_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_output", 32'(ram_read_data_o), 32'hFFFF_FFFF);
      else chk("read_data", 32'(ram_read_data_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write(input logic [SW-1:0] v, input bit accept);
    sample_i = v;
    sample_valid_i = 1'b1;
    if (accept) exp_q.push_back(v);
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    ram_read_ready_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    ram_read_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || ram_read_valid_o) && n < 80) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    chk({name, "_count"}, 32'(fill_count_o), 32'd0);
  endtask

  initial begin
    int n;
    // 1: reset and idle
    tick(); tick();
    rst_i = 1'b0;
    repeat (10) tick();
    chk("rst_valid", 32'(ram_read_valid_o), 0);
    chk("rst_data", 32'(ram_read_data_o), 0);
    chk("rst_bufrdy", 32'(ram_buffer_ready_o), 0);
    chk("rst_count", 32'(fill_count_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);

    // 2: single-sample latency
    ram_read_ready_i = 1'b1;
    write(24'h800001, 1'b1);
    chk("lat_e0_valid", 32'(ram_read_valid_o), 0);
    chk("lat_e0_count", 32'(fill_count_o), 1);
    tick();
    chk("lat_e1_valid", 32'(ram_read_valid_o), 0);
    chk("lat_e1_count", 32'(fill_count_o), 0);
    tick();
    chk("lat_e2_valid", 32'(ram_read_valid_o), 1);
    chk("lat_e2_data", 32'(ram_read_data_o), 32'h800001);
    tick();
    chk("lat_e3_valid", 32'(ram_read_valid_o), 0);
    chk("lat_e3_count", 32'(fill_count_o), 0);
    chk("lat_e3_sb", 32'(exp_q.size()), 0);

    // 3: buffer-ready hysteresis
    do_flush();
    for (int i = 1; i <= 4; i++) write(SW'(i), 1'b1);
    chk("hys_w4_count", 32'(fill_count_o), 3);
    chk("hys_w4_bufrdy", 32'(ram_buffer_ready_o), 0);
    write(SW'(5), 1'b1);
    chk("hys_w5_count", 32'(fill_count_o), 4);
    chk("hys_w5_bufrdy", 32'(ram_buffer_ready_o), 1);
    ram_read_ready_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      chk("hys_drain_bufrdy", 32'(ram_buffer_ready_o), 32'(exp_q.size() != 0));
    end while (exp_q.size() != 0 && n < 40);
    chk("hys_drain_done", 32'(exp_q.size()), 0);

    // 4: backpressure stability
    do_flush();
    write(24'h123456, 1'b1);
    n = 0;
    while (!ram_read_valid_o && n < 10) begin tick(); n++; end
    chk("bp_valid_rise", 32'(ram_read_valid_o), 1);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0 && i < 12) write(SW'(24'hA00000 + i), 1'b1);
      else tick();
      if (ram_read_valid_o !== 1'b1 || ram_read_data_o !== 24'h123456) begin
        chk("bp_hold_valid", 32'(ram_read_valid_o), 1);
        chk("bp_hold_data", 32'(ram_read_data_o), 32'h123456);
      end else vectors++;
    end
    chk("bp_count", 32'(fill_count_o), 6);
    drain("bp_drain");

    // 5: overflow
    do_flush();
    for (int i = 0; i < 10; i++) write(SW'(i), i < 9);
    chk("ovf_count", 32'(fill_count_o), 8);
    chk("ovf_flag", 32'(overflow_o), 1);
    drain("ovf_drain");
    chk("ovf_sticky", 32'(overflow_o), 1);

    // 6: wrap with random ready, then flush mid-stream
    do_flush();
    chk("fl_ovf_clear", 32'(overflow_o), 0);
    for (int i = 0; i < 3 * DP * 4; i++) begin
      ram_read_ready_i = ($urandom_range(0, 3) != 0);
      if (i % 4 == 0) write(SW'(24'h000100 + i / 4), 1'b1);
      else tick();
    end
    drain("wrap_drain");
    chk("wrap_ovf", 32'(overflow_o), 0);
    ram_read_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) write(SW'(24'h7F0000 + i), 1'b0);
    chk("pre_flush_ovf", 32'(overflow_o), 1);
    chk("pre_flush_valid", 32'(ram_read_valid_o), 1);
    do_flush();
    chk("flush_valid", 32'(ram_read_valid_o), 0);
    chk("flush_count", 32'(fill_count_o), 0);
    chk("flush_ovf", 32'(overflow_o), 0);
    chk("flush_bufrdy", 32'(ram_buffer_ready_o), 0);
    ram_read_ready_i = 1'b1;
    write(24'h00ABCD, 1'b1);
    drain("post_flush_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
